// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared types and constants for the DVS-to-RAVENS pipeline.
package dvs_ravens_pkg;
    localparam int RAVENS_PKT_BITS = 32;
    localparam int SPI_CLK_DIV     = 4;
    localparam int SPI_GAP_CYCLES  = 2;
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, TRAIL, GAP} spi_tx_state_t;
endpackage

// File: rtl/ravens_pkt_spi_tx.sv
// ravens_pkt_spi_tx: buffers one RAVENS packet and shifts it out on a SPI mode-0 master link.
module ravens_pkt_spi_tx
    import dvs_ravens_pkg::*;
#(
    parameter int PKT_BITS   = RAVENS_PKT_BITS,
    parameter int CLK_DIV    = SPI_CLK_DIV,
    parameter int GAP_CYCLES = SPI_GAP_CYCLES,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PKT_BITS-1:0] pkt_in,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    output logic                spi_sclk,
    output logic                spi_mosi,
    output logic                spi_cs_n,
    output logic                busy,
    output logic                tx_done
);
    localparam int BIT_W = $clog2(PKT_BITS);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    spi_tx_state_t       state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [PKT_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, tx_done_q, tx_done_d;
    logic                accept, expire;

    assign pkt_ready = !rst && (!hold_full_q || state_q == IDLE);
    assign accept    = pkt_valid && pkt_ready;
    assign expire    = div_cnt_q == DIV_W'(CLK_DIV - 1);
    assign busy      = state_q != IDLE || hold_full_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;
    assign tx_done   = tx_done_q;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = (expire || state_q == IDLE || state_q == GAP) ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = '0;
        shift_d     = shift_q;
        hold_d      = accept ? pkt_in : hold_q;
        hold_full_d = accept ? 1'b1 : hold_full_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        tx_done_d   = 1'b0;
        case (state_q)
            IDLE: if (hold_full_q) begin
                // A same-edge accept refills the hold while its old content moves to the shifter.
                shift_d     = hold_q;
                hold_full_d = accept;
                cs_n_d      = 1'b0;
                mosi_d      = MSB_FIRST ? hold_q[PKT_BITS-1] : hold_q[0];
                bit_cnt_d   = '0;
                state_d     = SETUP;
            end
            SETUP, SCK_LO: if (expire) begin
                sclk_d  = 1'b1;
                state_d = SCK_HI;
            end
            SCK_HI: if (expire) begin
                sclk_d = 1'b0;
                if (bit_cnt_q == BIT_W'(PKT_BITS - 1)) begin
                    state_d = TRAIL;
                end else begin
                    shift_d   = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
                    mosi_d    = MSB_FIRST ? shift_q[PKT_BITS-2] : shift_q[1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = SCK_LO;
                end
            end
            TRAIL: if (expire) begin
                cs_n_d    = 1'b1;
                tx_done_d = 1'b1;
                state_d   = GAP;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q == GAP_W'(GAP_CYCLES - 1) ? '0 : gap_cnt_q + 1'b1;
                state_d   = gap_cnt_q == GAP_W'(GAP_CYCLES - 1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            tx_done_q   <= tx_done_d;
        end
    end
endmodule

// File: tb/tb_ravens_pkt_spi_tx.sv
// tb_ravens_pkt_spi_tx: directed scoreboard bench; instance 0 is MSB-first, instance 1 LSB-first.
module tb_ravens_pkt_spi_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pkt_in [2];
    logic [1:0] pkt_valid = 2'b00;
    logic [1:0] pkt_ready, sclk, mosi, cs_n, busy, tx_done;
    int         vectors = 0, miscompares = 0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         low_cnt [2], nbits [2], high_cnt [2], last_gap [2];
    logic [7:0] rx [2];
    logic [7:0] exp_b;
    logic [1:0] sclk_p, cs_n_p, mosi_p;

    always #5 clk = ~clk;

    ravens_pkt_spi_tx #(.PKT_BITS(8), .CLK_DIV(2), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .pkt_in(pkt_in[0]), .pkt_valid(pkt_valid[0]), .pkt_ready(pkt_ready[0]),
        .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .busy(busy[0]), .tx_done(tx_done[0]));

    ravens_pkt_spi_tx #(.PKT_BITS(8), .CLK_DIV(2), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .pkt_in(pkt_in[1]), .pkt_valid(pkt_valid[1]), .pkt_ready(pkt_ready[1]),
        .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .busy(busy[1]), .tx_done(tx_done[1]));

    // Monitor: rebuilds each frame from the pins and checks it against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                low_cnt[k] = 0;
                nbits[k]   = 0;
                high_cnt[k] = 0;
            end
            sclk_p = 2'b00;
            cs_n_p = 2'b11;
            mosi_p = mosi;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (tx_done[k] != (cs_n[k] && !cs_n_p[k])) begin
                    miscompares++;
                    $display("FAIL tx_done_align[%0d]: tx_done=%b cs_n=%b prev_cs_n=%b", k, tx_done[k], cs_n[k], cs_n_p[k]);
                end
                if (!cs_n[k] && sclk[k] && mosi[k] != mosi_p[k]) begin
                    miscompares++;
                    $display("FAIL mosi_stable[%0d]: mosi changed to %b while sclk high", k, mosi[k]);
                end
                if (!cs_n[k]) begin
                    low_cnt[k]++;
                    if (sclk[k] && !sclk_p[k]) begin
                        nbits[k]++;
                        rx[k] = (k == 0) ? {rx[k][6:0], mosi[k]} : {mosi[k], rx[k][7:1]};
                    end
                end
                if (!cs_n[k] && cs_n_p[k]) last_gap[k] = high_cnt[k];
                if (cs_n[k]) high_cnt[k] = cs_n_p[k] ? high_cnt[k] + 1 : 1;
                if (cs_n[k] && !cs_n_p[k]) begin
                    vectors += 3;
                    if (low_cnt[k] != 34) begin
                        miscompares++;
                        $display("FAIL cs_low_cycles[%0d]: got %0d expected 34", k, low_cnt[k]);
                    end
                    if (nbits[k] != 8) begin
                        miscompares++;
                        $display("FAIL sclk_rises[%0d]: got %0d expected 8", k, nbits[k]);
                    end
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_frame[%0d]: got %h expected none", k, rx[k]);
                    end else begin
                        exp_b = (k == 0) ? q0.pop_front() : q1.pop_front();
                        if (rx[k] != exp_b) begin
                            miscompares++;
                            $display("FAIL frame_data[%0d]: got %h expected %h", k, rx[k], exp_b);
                        end
                    end
                    low_cnt[k] = 0;
                    nbits[k]   = 0;
                end
            end
            sclk_p = sclk;
            cs_n_p = cs_n;
            mosi_p = mosi;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        pkt_in[k]    = d;
        pkt_valid[k] = 1'b1;
        while (!pkt_ready[k] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!pkt_ready[k]) begin
            chk("send_timeout", 32'(pkt_ready[k]), 32'd1);
        end else begin
            @(posedge clk);
            if (k == 0) q0.push_back(d);
            else q1.push_back(d);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        pkt_valid[k] = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy != 2'b00 || cs_n != 2'b11) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < 5000), 32'd1);
    endtask

    initial begin
        logic [7:0] stall_pkts [5];
        logic       p;
        int         r, t;
        pkt_in[0] = 8'h00;
        pkt_in[1] = 8'h00;
        stall_pkts = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        // 1: reset state
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(pkt_ready), 32'd0);
        end
        chk("rst_cs_n", 32'(cs_n), 32'd3);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(pkt_ready), 32'd3);
        // 2: single frame
        send(0, 8'hA5);
        idle(0);
        wait_done();
        // 3: back-to-back with valid held high
        send(0, 8'h3C);
        send(0, 8'hC3);
        @(negedge clk);
        chk("ready_hold_full", 32'(pkt_ready[0]), 32'd0);
        pkt_valid[0] = 1'b0;
        wait_done();
        chk("gap_cycles", 32'(last_gap[0]), 32'd3);
        // 4: LSB-first
        send(1, 8'h01);
        idle(1);
        wait_done();
        // 5: reset mid-frame with a packet held
        send(0, 8'hFF);
        send(0, 8'h55);
        idle(0);
        r = 0;
        t = 0;
        p = sclk[0];
        while (r < 4 && t < 500) begin
            @(negedge clk);
            if (sclk[0] && !p) r++;
            p = sclk[0];
            t++;
        end
        chk("abort_reached_edge4", 32'(r), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_tx_done", 32'(tx_done[0]), 32'd0);
        chk("abort_ready", 32'(pkt_ready[0]), 32'd0);
        q0.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("discard_busy", 32'(busy[0]), 32'd0);
        chk("discard_cs_n", 32'(cs_n[0]), 32'd1);
        send(0, 8'h81);
        idle(0);
        wait_done();
        // 6: stalled upstream
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            send(0, stall_pkts[i]);
            idle(0);
        end
        wait_done();
        chk("queue_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
